// File: rtl/aes_imcol_seq.sv
// Sequential AES InvMixColumns, COLS_PER_CYCLE columns per clock, GF multiplies via EXP3/LN3 tables.
// Optional AES_IMCOL_SCRUB_EN: clear working register and State_out on the output handshake.
module aes_imcol_col (
    input  logic [31:0]   col_in,
    input  logic [2047:0] exp3,
    input  logic [2047:0] ln3,
    output logic [31:0]   col_out
);
    // Row-0 coefficients 0e,0b,0d,09 (low byte first); row r uses a rotation by r.
    localparam logic [31:0] K = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        if (x == 8'h00 || y == 8'h00) return 8'h00;
        s = {1'b0, ln3[8*x +: 8]} + {1'b0, ln3[8*y +: 8]};
        if (s >= 9'd255) s = s - 9'd255;
        if (s == 9'd255) s = 9'd0;
        return exp3[8*s[7:0] +: 8];
    endfunction

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                col_out[8*r +: 8] = col_out[8*r +: 8] ^
                                    gmul(col_in[8*j +: 8], K[8*((j - r + 4) % 4) +: 8]);
    end
endmodule

module aes_imcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  State_in,
    input  logic [2047:0] EXP3,
    input  logic [2047:0] LN3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  State_out
);
    localparam int NB = 4;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_imcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [2:0]   cnt;
    logic [127:0] work;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        logic [1:0]  ci;
        logic [31:0] cin;
        assign ci  = cnt[1:0] + 2'(l);
        assign cin = work[{ci, 5'b0} +: 32];
        aes_imcol_col u_col (
            .col_in (cin),
            .exp3   (EXP3),
            .ln3    (LN3),
            .col_out(lane_out[l])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // cnt == NB marks the extra BUSY cycle that publishes the finished state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: if (cnt == 3'(NB)) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            work      <= '0;
            State_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work <= State_in;
                    cnt  <= '0;
                end
                BUSY: begin
                    if (cnt == 3'(NB)) begin
                        State_out <= work;
                    end else begin
                        for (int l = 0; l < COLS_PER_CYCLE; l++)
                            work[{cnt[1:0] + 2'(l), 5'b0} +: 32] <= lane_out[l];
                        cnt <= cnt + 3'(COLS_PER_CYCLE);
                    end
                end
                DONE: begin
`ifdef AES_IMCOL_SCRUB_EN
                    if (out_ready) begin
                        work      <= '0;
                        State_out <= '0;
                    end
`else
                    cnt <= cnt;
`endif
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_imcol_seq.sv
// Scoreboard bench for aes_imcol_seq: one DUT per COLS_PER_CYCLE in {1,2,4}, directed vectors.
module tb_aes_imcol_seq;
    logic          clock = 0;
    logic [2047:0] exp3, ln3;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mkcol(input logic [7:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [127:0] V_SINGLE = {96'h0, mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    localparam logic [127:0] E_SINGLE = {96'h0, mkcol(8'hdb, 8'h13, 8'h53, 8'h45)};
    localparam logic [127:0] V_MIX = {mkcol(8'hc6, 8'hc6, 8'hc6, 8'hc6), mkcol(8'h01, 8'h01, 8'h01, 8'h01),
                                      mkcol(8'hd5, 8'hd5, 8'hd7, 8'hd6), mkcol(8'h9f, 8'hdc, 8'h58, 8'h9d)};
    localparam logic [127:0] E_MIX = {mkcol(8'hc6, 8'hc6, 8'hc6, 8'hc6), mkcol(8'h01, 8'h01, 8'h01, 8'h01),
                                      mkcol(8'hd4, 8'hd4, 8'hd4, 8'hd5), mkcol(8'hf2, 8'h0a, 8'h22, 8'h5c)};
    localparam logic [127:0] V_R = {4{mkcol(8'h4d, 8'h7e, 8'hbd, 8'hf8)}};
    localparam logic [127:0] E_R = {4{mkcol(8'h2d, 8'h26, 8'h31, 8'h4c)}};

    task automatic chk(input int cfg, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cols=%0d %s got %h want %h", cfg, nm, act, exp);
        end
    endtask

    initial begin
        logic [7:0] x;
        exp3 = '0;
        ln3  = '0;
        x    = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp3[8*i +: 8] = x;
            ln3[8*x +: 8]  = 8'(i);
            x = x ^ xt(x);
        end
        exp3[2047 -: 8] = 8'h01;
    end

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int C    = 1 << g;
        localparam int NCYC = 4 / C;

        logic         rst, in_valid, in_ready, out_valid, out_ready;
        logic [127:0] sin, sout;
        logic [127:0] exp_q[$];
        int           acc_q[$];

        aes_imcol_seq #(.COLS_PER_CYCLE(C)) dut (
            .clock    (clock),
            .reset    (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .State_in (sin),
            .EXP3     (exp3),
            .LN3      (ln3),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .State_out(sout)
        );

        task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output int acc);
            int t;
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clock); #1;
                t++;
            end
            if (!in_ready) chk(C, "in_ready timeout", 128'(in_ready), 128'(1));
            sin      = d;
            in_valid = 1'b1;
            @(posedge clock); #1;
            acc      = cyc;
            in_valid = 1'b0;
            sin      = ~d;
            if (push) begin
                exp_q.push_back(e);
                acc_q.push_back(acc);
            end
        endtask

        task automatic drain();
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(posedge clock); #1;
                t++;
            end
            if (exp_q.size() != 0) chk(C, "drain timeout", 128'(exp_q.size()), 128'(0));
        endtask

        initial begin : mon
            logic         pv;
            logic [127:0] e;
            int           a;
            pv = 1'b0;
            forever begin
                @(negedge clock);
                if (out_valid && !pv) begin
                    if (acc_q.size() == 0) chk(C, "unexpected out_valid", 128'(out_valid), 128'(0));
                    else begin
                        a = acc_q.pop_front();
                        chk(C, "latency", 128'(cyc - a), 128'(NCYC + 1));
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(C, "result", sout, e);
                end
                pv = out_valid;
            end
        end

        initial begin : stim
            int a0, a1, a2, t;
            rst = 1'b1; in_valid = 1'b0; sin = '0; out_ready = 1'b1;
            repeat (2) @(posedge clock);
            #1;
            chk(C, "reset in_ready", 128'(in_ready), 128'(1));
            chk(C, "reset out_valid", 128'(out_valid), 128'(0));
            chk(C, "reset State_out", sout, '0);
            rst = 1'b0;

            send(V_SINGLE, E_SINGLE, 1'b1, a0);
            send(V_MIX, E_MIX, 1'b1, a0);
            drain();

            // Output stall: held result, no accept, in_valid ignored.
            out_ready = 1'b0;
            send(V_R, E_R, 1'b1, a0);
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clock); #1;
                t++;
            end
            for (int i = 0; i < 10; i++) begin
                chk(C, "stall State_out", sout, E_R);
                chk(C, "stall in_ready", 128'(in_ready), 128'(0));
                chk(C, "stall out_valid", 128'(out_valid), 128'(1));
                in_valid = i[0];
                sin      = V_MIX;
                @(posedge clock); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clock); #1;
            chk(C, "post-handshake in_ready", 128'(in_ready), 128'(1));
            chk(C, "post-handshake out_valid", 128'(out_valid), 128'(0));
`ifdef AES_IMCOL_SCRUB_EN
            chk(C, "scrubbed State_out", sout, '0);
`else
            chk(C, "retained State_out", sout, E_R);
`endif
            drain();

            // Reset during the second BUSY cycle aborts without output.
            send(V_MIX, E_MIX, 1'b0, a0);
            @(posedge clock); #1;
            rst = 1'b1;
            @(posedge clock); #1;
            rst = 1'b0;
            chk(C, "abort out_valid", 128'(out_valid), 128'(0));
            chk(C, "abort in_ready", 128'(in_ready), 128'(1));
            chk(C, "abort State_out", sout, '0);
            send(V_R, E_R, 1'b1, a0);
            drain();

            // Back-to-back with out_ready tied high.
            send(V_SINGLE, E_SINGLE, 1'b1, a0);
            send(V_MIX, E_MIX, 1'b1, a1);
            send(V_R, E_R, 1'b1, a2);
            chk(C, "accept spacing 1", 128'(a1 - a0), 128'(NCYC + 3));
            chk(C, "accept spacing 2", 128'(a2 - a1), 128'(NCYC + 3));
            drain();
            repeat (3) @(posedge clock);
            done_cnt++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (done_cnt < 3 && t < 20000) begin
            @(posedge clock);
            t++;
        end
        if (done_cnt < 3) chk(0, "run timeout", 128'(done_cnt), 128'(3));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
